// File: rtl/fft_out_serializer.sv
// FFT output stage: captures 16-lane natural-order bursts into a ping-pong frame buffer
// and streams one complex bin per cycle over valid/ready, flagging dropped and short frames.
module fft_out_serializer #(
   parameter int unsigned WIDTH     = 13,
   parameter int unsigned ARRAY_IN  = 16,
   parameter int unsigned MAX_POINT = 512
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      din_en,
   input  logic [WIDTH*ARRAY_IN-1:0] din_re,
   input  logic [WIDTH*ARRAY_IN-1:0] din_im,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [WIDTH-1:0]          dout_re,
   output logic [WIDTH-1:0]          dout_im,
   output logic [8:0]                dout_idx,
   output logic                      dout_last,
   output logic                      ovf,
   output logic                      short_err
);

   localparam int unsigned BEATS = MAX_POINT / ARRAY_IN;
   localparam int unsigned CW    = $clog2(BEATS);
   localparam int unsigned LW    = $clog2(ARRAY_IN);
   localparam int unsigned AW    = $clog2(MAX_POINT);

   typedef enum logic {StIdle, StStream} state_e;

   logic [2*WIDTH-1:0] r_bank0 [MAX_POINT];
   logic [2*WIDTH-1:0] r_bank1 [MAX_POINT];

   logic [CW-1:0]      r_wcnt;
   logic               r_wb, r_rb, r_drop, r_ovf, r_short;
   logic [1:0]         r_full, w_full_d;
   state_e             r_state, w_state_d;
   logic [WIDTH-1:0]   r_re, r_im;
   logic [AW-1:0]      r_idx;

   logic               w_beat0, w_drop, w_we, w_last_beat, w_set;
   logic               w_hs, w_load, w_rel, w_rd_bank;
   logic [AW-1:0]      w_rd_addr;
   logic [2*WIDTH-1:0] w_rd_word;

   // Drop decision is made on beat 0 from the registered full flag and held for the burst.
   assign w_beat0     = din_en && (r_wcnt == '0);
   assign w_drop      = w_beat0 ? r_full[r_wb] : r_drop;
   assign w_we        = din_en && !w_drop;
   assign w_last_beat = din_en && (r_wcnt == CW'(BEATS - 1));
   assign w_set       = w_we && w_last_beat;

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int i = 0; i < int'(ARRAY_IN); i++) begin
            if (r_wb) begin
               r_bank1[{r_wcnt, LW'(i)}] <= {din_re[i*WIDTH +: WIDTH], din_im[i*WIDTH +: WIDTH]};
            end else begin
               r_bank0[{r_wcnt, LW'(i)}] <= {din_re[i*WIDTH +: WIDTH], din_im[i*WIDTH +: WIDTH]};
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wcnt  <= '0;
         r_wb    <= 1'b0;
         r_drop  <= 1'b0;
         r_ovf   <= 1'b0;
         r_short <= 1'b0;
      end else begin
         r_ovf   <= w_beat0 && r_full[r_wb];
         r_short <= !din_en && (r_wcnt != '0);
         if (din_en) begin
            r_wcnt <= w_last_beat ? '0 : r_wcnt + 1'b1;
         end else begin
            r_wcnt <= '0;
         end
         if (w_beat0) begin
            r_drop <= r_full[r_wb];
         end
         if (w_set) begin
            r_wb <= ~r_wb;
         end
      end
   end

   // Writer and reader never own the same bank, so set and clear cannot collide.
   always_comb begin
      w_full_d = r_full;
      for (int b = 0; b < 2; b++) begin
         if (w_set && (r_wb == b[0])) begin
            w_full_d[b] = 1'b1;
         end else if (w_rel && (r_rb == b[0])) begin
            w_full_d[b] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 2'b00;
      end else begin
         r_full <= w_full_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   assign w_hs = dout_valid && dout_ready;

   always_comb begin
      w_state_d = r_state;
      w_load    = 1'b0;
      w_rel     = 1'b0;
      w_rd_bank = r_rb;
      w_rd_addr = '0;
      unique case (r_state)
         StIdle: begin
            if (r_full[r_rb]) begin
               w_load    = 1'b1;
               w_state_d = StStream;
            end
         end
         StStream: begin
            if (w_hs) begin
               if (r_idx == AW'(MAX_POINT - 1)) begin
                  w_rel     = 1'b1;
                  w_rd_bank = ~r_rb;
                  if (r_full[~r_rb]) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_d = StIdle;
                  end
               end else begin
                  w_load    = 1'b1;
                  w_rd_addr = r_idx + 1'b1;
               end
            end
         end
      endcase
   end

   assign w_rd_word = w_rd_bank ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_re  <= '0;
         r_im  <= '0;
         r_idx <= '0;
         r_rb  <= 1'b0;
      end else begin
         if (w_load) begin
            r_re  <= w_rd_word[2*WIDTH-1:WIDTH];
            r_im  <= w_rd_word[WIDTH-1:0];
            r_idx <= w_rd_addr;
         end
         if (w_rel) begin
            r_rb <= ~r_rb;
         end
      end
   end

   always_comb begin
      dout_valid = (r_state == StStream);
      dout_last  = dout_valid && (r_idx == AW'(MAX_POINT - 1));
      dout_re    = r_re;
      dout_im    = r_im;
      dout_idx   = r_idx;
      ovf        = r_ovf;
      short_err  = r_short;
   end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: frames of known data, expected-sample queue,
// stall stability, latency, overflow, short burst and mid-stream reset.
module tb_fft_out_serializer;

   localparam int W = 13;
   localparam int L = 16;
   localparam int N = 512;

   typedef struct {
      int re;
      int im;
      int idx;
   } samp_t;

   logic           clk, rst, din_en, dout_valid, dout_ready, dout_last, ovf, short_err;
   logic [W*L-1:0] din_re, din_im;
   logic [W-1:0]   dout_re, dout_im;
   logic [8:0]     dout_idx;

   samp_t exp_q[$];
   int    n_tests, n_fail;
   int    hs_cnt, v_cycles, v_rises, ovf_cnt, short_cnt;
   int    rmode;

   fft_out_serializer #(.WIDTH(W), .ARRAY_IN(L), .MAX_POINT(N)) dut (
      .clk(clk), .rst(rst), .din_en(din_en), .din_re(din_re), .din_im(din_im),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_re(dout_re), .dout_im(dout_im),
      .dout_idx(dout_idx), .dout_last(dout_last), .ovf(ovf), .short_err(short_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mon_loop();
      logic           prev_v, prev_stall;
      logic [2*W+8:0] prev_word;
      samp_t          s;
      prev_v = 1'b0;
      prev_stall = 1'b0;
      prev_word = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (dout_valid && !prev_v) v_rises++;
            if (dout_valid) v_cycles++;
            if (ovf) ovf_cnt++;
            if (short_err) short_cnt++;
            if (prev_stall) check("stall_hold", int'({dout_re, dout_im, dout_idx} == prev_word), 1);
            if (dout_valid) check("last_flag", dout_last, int'(dout_idx == 9'd511));
            if (dout_valid && dout_ready) begin
               hs_cnt++;
               check("unexpected_sample", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  s = exp_q.pop_front();
                  check("dout_idx", dout_idx, s.idx);
                  check("dout_re", int'($signed(dout_re)), s.re);
                  check("dout_im", int'($signed(dout_im)), s.im);
               end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_word = {dout_re, dout_im, dout_idx};
            prev_v = dout_valid;
         end
      end
   endtask

   // Mode 0: ready high, 1: one on / two off after each handshake, 2: ready low.
   task automatic ready_loop();
      logic hs_now;
      int   ph;
      ph = 0;
      forever begin
         @(negedge clk);
         hs_now = dout_valid && dout_ready;
         @(posedge clk);
         #1;
         if (rmode == 1) begin
            if (hs_now) ph = 1;
            else if (ph != 0) ph = (ph == 2) ? 0 : ph + 1;
            dout_ready = (ph == 0);
         end else begin
            ph = 0;
            dout_ready = (rmode == 0);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int k, input int off);
      for (int i = 0; i < L; i++) begin
         din_re[i*W +: W] = W'(16 * k + i + off);
         din_im[i*W +: W] = W'(-(16 * k + i) - off);
      end
      din_en = 1'b1;
      tick();
   endtask

   task automatic send_frame(input int off, input bit accept, input bit exp_ovf);
      samp_t s;
      if (accept) begin
         for (int b = 0; b < N; b++) begin
            s.re = b + off;
            s.im = -b - off;
            s.idx = b;
            exp_q.push_back(s);
         end
      end
      for (int k = 0; k < N / L; k++) begin
         beat(k, off);
         if (k == 0) check("ovf_after_beat0", ovf, int'(exp_ovf));
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || dout_valid) && c < budget) begin
         tick();
         c++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      check({tag, "_idle"}, dout_valid, 0);
   endtask

   initial begin
      int b_hs, b_v, b_r, b_o, b_s, c;
      n_tests = 0; n_fail = 0;
      hs_cnt = 0; v_cycles = 0; v_rises = 0; ovf_cnt = 0; short_cnt = 0;
      rst = 1'b1; din_en = 1'b0; din_re = '0; din_im = '0; dout_ready = 1'b0; rmode = 0;
      fork
         mon_loop();
         ready_loop();
         begin
            #2000000;
            $display("FAIL watchdog: got timeout, expected completion");
            $fatal(1, "watchdog");
         end
      join_none
      repeat (3) tick();
      check("rst_valid", dout_valid, 0);
      check("rst_re", dout_re, 0);
      check("rst_im", dout_im, 0);
      check("rst_idx", dout_idx, 0);
      check("rst_last", dout_last, 0);
      check("rst_ovf", ovf, 0);
      check("rst_short", short_err, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Single frame, ready high: latency and full sequence.
      b_hs = hs_cnt; b_r = v_rises; b_o = ovf_cnt;
      send_frame(0, 1, 0);
      din_en = 1'b0;
      check("lat_not_yet", dout_valid, 0);
      tick();
      check("lat_valid", dout_valid, 1);
      check("lat_first_idx", dout_idx, 0);
      wait_idle("t1", 700);
      check("t1_count", hs_cnt - b_hs, 512);
      check("t1_rises", v_rises - b_r, 1);
      check("t1_no_ovf", ovf_cnt - b_o, 0);

      // Same frame under 1-on / 2-off ready pattern.
      rmode = 1;
      tick();
      b_hs = hs_cnt; b_v = v_cycles;
      send_frame(0, 1, 0);
      din_en = 1'b0;
      wait_idle("t2", 2000);
      check("t2_count", hs_cnt - b_hs, 512);
      check("t2_cycles", v_cycles - b_v, 1534);
      rmode = 0;
      repeat (2) tick();

      // Back-to-back frames: one contiguous 1024-sample burst.
      b_hs = hs_cnt; b_v = v_cycles; b_r = v_rises;
      send_frame(1000, 1, 0);
      send_frame(2000, 1, 0);
      din_en = 1'b0;
      wait_idle("t3", 1200);
      check("t3_count", hs_cnt - b_hs, 1024);
      check("t3_cycles", v_cycles - b_v, 1024);
      check("t3_rises", v_rises - b_r, 1);

      // Three frames with ready low: third is dropped.
      rmode = 2;
      repeat (2) tick();
      b_hs = hs_cnt; b_o = ovf_cnt;
      send_frame(100, 1, 0);
      send_frame(200, 1, 0);
      send_frame(300, 0, 1);
      din_en = 1'b0;
      repeat (5) tick();
      check("t4_stalled_valid", dout_valid, 1);
      check("t4_no_hs", hs_cnt - b_hs, 0);
      check("t4_ovf_once", ovf_cnt - b_o, 1);
      rmode = 0;
      wait_idle("t4", 1200);
      check("t4_count", hs_cnt - b_hs, 1024);

      // Short burst, then a good frame.
      b_hs = hs_cnt; b_s = short_cnt;
      for (int k = 0; k < 10; k++) beat(k, 0);
      din_en = 1'b0;
      tick();
      check("t5_short_pulse", short_err, 1);
      tick();
      check("t5_short_end", short_err, 0);
      repeat (40) tick();
      check("t5_no_output", hs_cnt - b_hs, 0);
      check("t5_short_once", short_cnt - b_s, 1);
      check("t5_idle", dout_valid, 0);
      send_frame(500, 1, 0);
      din_en = 1'b0;
      wait_idle("t5", 700);
      check("t5_count", hs_cnt - b_hs, 512);

      // Reset mid-stream at sample 200.
      b_hs = hs_cnt;
      send_frame(700, 1, 0);
      din_en = 1'b0;
      c = 0;
      while (hs_cnt - b_hs < 200 && c < 1000) begin
         tick();
         c++;
      end
      check("t6_reached_200", hs_cnt - b_hs, 200);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", dout_valid, 0);
      check("t6_rst_re", dout_re, 0);
      check("t6_rst_idx", dout_idx, 0);
      exp_q.delete();
      tick();
      check("t6_rst_im", dout_im, 0);
      check("t6_rst_last", dout_last, 0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("t6_stay_idle", dout_valid, 0);
      b_hs = hs_cnt;
      send_frame(800, 1, 0);
      din_en = 1'b0;
      wait_idle("t6", 700);
      check("t6_count", hs_cnt - b_hs, 512);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
